eth_bus_arbiter: RTL and testbench
==================================

Name: eth_bus_arbiter

Overview:
- Shares the single KSZ8851 register-access sequencer between three requester FSMs: Initialization (index 0), Transmission (index 1) and Reception (index 2).
- Each requester drives its own offset/length/WR/writeData/NewCommand/Dummy_Read bundle. The arbiter muxes the granted bundle to the sequencer and broadcasts the sequencer state and read data back to all requesters.
- Grants change only when the sequencer is idle in its Wait state, so a register access is never split between owners.
- A watchdog reclaims the bus from a hung owner.

Parameters:
- TIMEOUT_CYCLES, 65535: max cycles one grant may be held before forced release (1..65535).
- WAIT_STATE, 4'b1001: sequencer state code meaning idle/Wait.

Ports:
- sysclk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  3  per-requester bus request; held high for the whole multi-access sequence.
- req_offset  in  24  {rx[23:16], tx[15:8], init[7:0]} register offsets.
- req_length  in  3  per-requester length bit.
- req_wr  in  3  per-requester WR.
- req_wdata  in  48  {rx[47:32], tx[31:16], init[15:0]} write data.
- req_newcmd  in  3  per-requester NewCommand.
- req_dummy  in  3  per-requester Dummy_Read.
- grant  out  3  one-hot grant; at most one bit set.
- offset  out  8  to sequencer.
- length  out  1  to sequencer.
- WR  out  1  to sequencer.
- writeData  out  16  to sequencer.
- NewCommand  out  1  to sequencer.
- Dummy_Read  out  1  to sequencer.
- state  in  4  sequencer state.
- busy  out  1  high whenever FSM is not IDLE.
- timeout_err  out  1  one-cycle pulse on forced release.
- timeout_owner  out  2  index of last timed-out owner; sticky until reset.

Behaviour:
- Reset values: grant=0, busy=0, timeout_err=0, timeout_owner=0, FSM=IDLE, rr_next=1, timer=0. Reset mid-grant drops grant on the next edge with no drain.
- Bus outputs are combinational from the registered grant.
  - grant[i] set: outputs = bundle i.
  - grant=0: offset=0, length=0, WR=0, writeData=16'h0000, NewCommand=0, Dummy_Read=0.
  - No tristate is driven internally.
- state, readData and sequencer handshakes are not muxed; requesters qualify them with their own grant bit.
- FSM states: IDLE, GRANT, DRAIN, GUARD.
- IDLE:
  - If req!=0, register a winner: grant set at edge E, next state GRANT.
  - Priority: req[0] always wins.
  - Otherwise, if both req[1] and req[2] are set, rr_next selects the winner. If only one is set, that one wins.
  - On granting 1, rr_next<=2. On granting 2, rr_next<=1. Granting 0 leaves rr_next unchanged.
- GRANT:
  - timer increments every cycle and clears on entry.
  - Owner req low AND owner req_newcmd low: grant<=0, go DRAIN.
  - A req drop while the owner's NewCommand is still high is ignored until NewCommand falls.
  - timer==TIMEOUT_CYCLES-1 with the owner still holding: grant<=0, timeout_err pulse, timeout_owner<=owner index, go DRAIN.
  - Timeout takes precedence if it coincides with a normal release.
  - Higher-priority requests never preempt an active grant.
- DRAIN: bus outputs idle. Stay until state==WAIT_STATE, then go GUARD. If state is already WAIT_STATE on entry, leave after 1 cycle.
- GUARD: one cycle, then IDLE.
- Latency:
  - From idle, req rising before edge E gives grant at edge E.
  - Release detected at edge N, sequencer in Wait gives the earliest next grant at edge N+3.
- A requester dropping and re-raising req while another requester is pending competes normally.
- req bits for non-owners may toggle freely and have no effect during GRANT/DRAIN/GUARD.

Test Plan:
- Reset asserted during GRANT of rx -> next edge grant=000, busy=0, NewCommand=0, writeData=0.
- req=110 from IDLE, state=Wait -> grant=010 (tx, rr_next reset =1). Release tx with req=100 still high -> rx granted exactly 3 edges after release; offset equals req_offset[23:16].
- req=111 from IDLE -> grant=001. Init holds 20 cycles and releases -> tx granted next (rr_next=1), then rx after tx releases.
- Owner tx drops req while req_newcmd[1]=1 -> grant stays 010 until newcmd falls. In DRAIN, state held at Read1 for 5 cycles -> no new grant until state returns to 4'b1001.
- TIMEOUT_CYCLES=16, rx holds req forever -> grant drops after 16 cycles in GRANT, timeout_err high exactly 1 cycle, timeout_owner=2. A pending tx is then granted after DRAIN and GUARD.
- Simultaneous timeout and owner release on the same edge -> timeout_err still pulses, and the single DRAIN/GUARD sequence is unchanged.

Source files
------------

// File: rtl/eth_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// eth_bus_arbiter_if
// Bundles every signal between the three requester FSMs, the KSZ8851
// register-access sequencer and the arbiter.
//   Requester side : req, req_offset, req_length, req_wr, req_wdata,
//                    req_newcmd, req_dummy (packed {rx, tx, init})
//   Sequencer side : offset, length, WR, writeData, NewCommand, Dummy_Read
//                    (arbiter outputs) and state (sequencer input)
//   Status         : grant, busy, timeout_err, timeout_owner
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + sequencer) that drives it
// ---------------------------------------------------------------------------
interface eth_bus_arbiter_if;
  logic [2:0]  req;
  logic [23:0] req_offset;
  logic [2:0]  req_length;
  logic [2:0]  req_wr;
  logic [47:0] req_wdata;
  logic [2:0]  req_newcmd;
  logic [2:0]  req_dummy;

  logic [2:0]  grant;
  logic [7:0]  offset;
  logic        length;
  logic        WR;
  logic [15:0] writeData;
  logic        NewCommand;
  logic        Dummy_Read;

  logic [3:0]  state;
  logic        busy;
  logic        timeout_err;
  logic [1:0]  timeout_owner;

  modport slave (
    input  req, req_offset, req_length, req_wr, req_wdata, req_newcmd,
           req_dummy, state,
    output grant, offset, length, WR, writeData, NewCommand, Dummy_Read,
           busy, timeout_err, timeout_owner
  );

  modport master (
    output req, req_offset, req_length, req_wr, req_wdata, req_newcmd,
           req_dummy, state,
    input  grant, offset, length, WR, writeData, NewCommand, Dummy_Read,
           busy, timeout_err, timeout_owner
  );
endinterface

// File: rtl/eth_bus_arbiter.sv
// ---------------------------------------------------------------------------
// eth_bus_arbiter
// Shares one KSZ8851 register-access sequencer between the Initialization
// (0), Transmission (1) and Reception (2) requester FSMs. Init has fixed top
// priority; tx/rx alternate round-robin when both request. Ownership only
// changes once the sequencer is back in its Wait state, and a watchdog takes
// the bus back from an owner that holds it too long.
// Ports:
//   sysclk - system clock, everything on posedge
//   reset  - synchronous active-high reset
//   bus    - eth_bus_arbiter_if.slave (requests, sequencer bus, status)
// Parameters:
//   TIMEOUT_CYCLES - max cycles a grant may be held (1..65535)
//   WAIT_STATE     - sequencer state code meaning idle/Wait
// ---------------------------------------------------------------------------
module eth_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 32'd65535,
  parameter logic [3:0]  WAIT_STATE     = 4'b1001
) (
  input logic              sysclk,
  input logic              reset,
  eth_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  // Timer value seen on the last permitted cycle of a grant.
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  arb_state_e  fsm_q, fsm_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  rr_next_q, rr_next_d;
  logic [15:0] timer_q, timer_d;
  logic        busy_q, busy_d;
  logic        timeout_err_q, timeout_err_d;
  logic [1:0]  timeout_owner_q, timeout_owner_d;
  logic        owner_hold_s;

  // The owner keeps the bus while either its request or its NewCommand is up,
  // so a request drop mid-command never splits an access.
  assign owner_hold_s = (|(bus.req & grant_q)) | (|(bus.req_newcmd & grant_q));

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    fsm_d           = fsm_q;
    grant_d         = grant_q;
    owner_d         = owner_q;
    rr_next_d       = rr_next_q;
    timer_d         = timer_q;
    timeout_err_d   = 1'b0;
    timeout_owner_d = timeout_owner_q;
    case (fsm_q)
      ST_IDLE: begin
        timer_d = 16'd0;
        if (bus.req[0]) begin
          grant_d = 3'b001;
          owner_d = 2'd0;
          fsm_d   = ST_GRANT;
        end else if (bus.req[1] && (!bus.req[2] || (rr_next_q == 2'd1))) begin
          grant_d   = 3'b010;
          owner_d   = 2'd1;
          rr_next_d = 2'd2;
          fsm_d     = ST_GRANT;
        end else if (bus.req[2]) begin
          grant_d   = 3'b100;
          owner_d   = 2'd2;
          rr_next_d = 2'd1;
          fsm_d     = ST_GRANT;
        end else begin
          fsm_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        timer_d = timer_q + 16'd1;
        // Watchdog is checked first so it wins over a coincident release.
        if (timer_q == TIMER_LAST) begin
          grant_d         = 3'b000;
          timeout_err_d   = 1'b1;
          timeout_owner_d = owner_q;
          fsm_d           = ST_DRAIN;
        end else if (!owner_hold_s) begin
          grant_d = 3'b000;
          fsm_d   = ST_DRAIN;
        end else begin
          fsm_d = ST_GRANT;
        end
      end
      ST_DRAIN: begin
        if (bus.state == WAIT_STATE) begin
          fsm_d = ST_GUARD;
        end else begin
          fsm_d = ST_DRAIN;
        end
      end
      ST_GUARD: begin
        fsm_d = ST_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        fsm_d   = ST_IDLE;
      end
    endcase
    busy_d = (fsm_d != ST_IDLE);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      fsm_q           <= ST_IDLE;
      grant_q         <= 3'b000;
      owner_q         <= 2'd0;
      rr_next_q       <= 2'd1;
      timer_q         <= 16'd0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
      timeout_owner_q <= 2'd0;
    end else begin
      fsm_q           <= fsm_d;
      grant_q         <= grant_d;
      owner_q         <= owner_d;
      rr_next_q       <= rr_next_d;
      timer_q         <= timer_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
      timeout_owner_q <= timeout_owner_d;
    end
  end

  // Sequencer bus mux, driven from the registered grant; all-zero when idle.
  always_comb begin
    bus.offset     = 8'h00;
    bus.length     = 1'b0;
    bus.WR         = 1'b0;
    bus.writeData  = 16'h0000;
    bus.NewCommand = 1'b0;
    bus.Dummy_Read = 1'b0;
    case (grant_q)
      3'b001: begin
        bus.offset     = bus.req_offset[7:0];
        bus.length     = bus.req_length[0];
        bus.WR         = bus.req_wr[0];
        bus.writeData  = bus.req_wdata[15:0];
        bus.NewCommand = bus.req_newcmd[0];
        bus.Dummy_Read = bus.req_dummy[0];
      end
      3'b010: begin
        bus.offset     = bus.req_offset[15:8];
        bus.length     = bus.req_length[1];
        bus.WR         = bus.req_wr[1];
        bus.writeData  = bus.req_wdata[31:16];
        bus.NewCommand = bus.req_newcmd[1];
        bus.Dummy_Read = bus.req_dummy[1];
      end
      3'b100: begin
        bus.offset     = bus.req_offset[23:16];
        bus.length     = bus.req_length[2];
        bus.WR         = bus.req_wr[2];
        bus.writeData  = bus.req_wdata[47:32];
        bus.NewCommand = bus.req_newcmd[2];
        bus.Dummy_Read = bus.req_dummy[2];
      end
      default: begin
        bus.offset     = 8'h00;
        bus.length     = 1'b0;
        bus.WR         = 1'b0;
        bus.writeData  = 16'h0000;
        bus.NewCommand = 1'b0;
        bus.Dummy_Read = 1'b0;
      end
    endcase
  end

  assign bus.grant         = grant_q;
  assign bus.busy          = busy_q;
  assign bus.timeout_err   = timeout_err_q;
  assign bus.timeout_owner = timeout_owner_q;

endmodule

// File: tb/tb_eth_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_bus_arbiter
// Two arbiters share one stimulus stream: dut_a with the default watchdog
// (65535) and dut_b with a 16-cycle watchdog. A behavioural model tracks
// ownership, release/settle/gap timing and the round-robin pointer for each
// and is compared against every output on every falling edge. Directed
// checks with literal values pin the model at key points.
// ---------------------------------------------------------------------------
module tb_eth_bus_arbiter;

  logic        sysclk;
  logic        reset;
  logic [2:0]  req;
  logic [23:0] req_offset;
  logic [2:0]  req_length;
  logic [2:0]  req_wr;
  logic [47:0] req_wdata;
  logic [2:0]  req_newcmd;
  logic [2:0]  req_dummy;
  logic [3:0]  seq_state;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] WAIT_ST  = 4'b1001;
  localparam logic [3:0] READ1_ST = 4'b0011;

  eth_bus_arbiter_if if_a ();
  eth_bus_arbiter_if if_b ();

  assign if_a.req = req;          assign if_b.req = req;
  assign if_a.req_offset = req_offset; assign if_b.req_offset = req_offset;
  assign if_a.req_length = req_length; assign if_b.req_length = req_length;
  assign if_a.req_wr = req_wr;    assign if_b.req_wr = req_wr;
  assign if_a.req_wdata = req_wdata;   assign if_b.req_wdata = req_wdata;
  assign if_a.req_newcmd = req_newcmd; assign if_b.req_newcmd = req_newcmd;
  assign if_a.req_dummy = req_dummy;   assign if_b.req_dummy = req_dummy;
  assign if_a.state = seq_state;  assign if_b.state = seq_state;

  eth_bus_arbiter #(.TIMEOUT_CYCLES(65535), .WAIT_STATE(4'b1001)) dut_a (
    .sysclk(sysclk), .reset(reset), .bus(if_a));
  eth_bus_arbiter #(.TIMEOUT_CYCLES(16), .WAIT_STATE(4'b1001)) dut_b (
    .sysclk(sysclk), .reset(reset), .bus(if_b));

  logic [2:0]  d_grant [2];
  logic        d_busy  [2];
  logic        d_terr  [2];
  logic [1:0]  d_towner[2];
  logic [27:0] d_bus   [2];

  assign d_grant[0]  = if_a.grant;         assign d_grant[1]  = if_b.grant;
  assign d_busy[0]   = if_a.busy;          assign d_busy[1]   = if_b.busy;
  assign d_terr[0]   = if_a.timeout_err;   assign d_terr[1]   = if_b.timeout_err;
  assign d_towner[0] = if_a.timeout_owner; assign d_towner[1] = if_b.timeout_owner;
  assign d_bus[0] = {if_a.offset, if_a.length, if_a.WR, if_a.writeData,
                     if_a.NewCommand, if_a.Dummy_Read};
  assign d_bus[1] = {if_b.offset, if_b.length, if_b.WR, if_b.writeData,
                     if_b.NewCommand, if_b.Dummy_Read};

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ---------------- behavioural model ----------------
  int m_limit [2] = '{65535, 16};
  int m_owner [2] = '{-1, -1};  // -1: nobody owns the bus
  int m_held  [2] = '{0, 0};    // completed cycles of the current grant
  bit m_settle[2] = '{0, 0};    // released, waiting for sequencer Wait
  int m_gap   [2] = '{0, 0};    // idle edges before arbitration resumes
  int m_rr    [2] = '{1, 1};    // which of tx/rx wins a tie
  bit m_terr  [2] = '{0, 0};
  int m_towner[2] = '{0, 0};

  task automatic model_step();
    int w;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_owner[k] = -1; m_held[k] = 0; m_settle[k] = 1'b0;
        m_gap[k] = 0; m_rr[k] = 1; m_terr[k] = 1'b0; m_towner[k] = 0;
      end else begin
        m_terr[k] = 1'b0;
        if (m_owner[k] >= 0) begin
          if (m_held[k] == m_limit[k] - 1) begin
            m_terr[k] = 1'b1;
            m_towner[k] = m_owner[k];
            m_owner[k] = -1;
            m_settle[k] = 1'b1;
          end else if (!req[m_owner[k]] && !req_newcmd[m_owner[k]]) begin
            m_owner[k] = -1;
            m_settle[k] = 1'b1;
          end else begin
            m_held[k] = m_held[k] + 1;
          end
        end else if (m_settle[k]) begin
          if (seq_state == WAIT_ST) begin
            m_settle[k] = 1'b0;
            m_gap[k] = 1;
          end
        end else if (m_gap[k] > 0) begin
          m_gap[k] = m_gap[k] - 1;
        end else if (req != 3'b000) begin
          if (req[0]) w = 0;
          else if (req[1] && req[2]) w = m_rr[k];
          else if (req[1]) w = 1;
          else w = 2;
          if (w == 1) m_rr[k] = 2;
          if (w == 2) m_rr[k] = 1;
          m_owner[k] = w;
          m_held[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [27:0] exp_bus(int o);
    if (o < 0) return 28'h0;
    return {req_offset[o*8 +: 8], req_length[o], req_wr[o],
            req_wdata[o*16 +: 16], req_newcmd[o], req_dummy[o]};
  endfunction

  task automatic chk(string name, logic [47:0] act, logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge sysclk);
      model_step();
    end
  end

  // Per-cycle comparison of both arbiters against the model.
  initial begin
    logic [2:0] eg;
    @(posedge sysclk);
    forever begin
      @(negedge sysclk);
      for (int k = 0; k < 2; k++) begin
        eg = 3'b000;
        if (m_owner[k] >= 0) eg[m_owner[k]] = 1'b1;
        chk($sformatf("model_grant_dut%0d", k), 48'(d_grant[k]), 48'(eg));
        chk($sformatf("model_busy_dut%0d", k), 48'(d_busy[k]),
            48'((m_owner[k] >= 0) || m_settle[k] || (m_gap[k] > 0)));
        chk($sformatf("model_terr_dut%0d", k), 48'(d_terr[k]), 48'(m_terr[k]));
        chk($sformatf("model_towner_dut%0d", k), 48'(d_towner[k]), 48'(m_towner[k]));
        chk($sformatf("model_bus_dut%0d", k), 48'(d_bus[k]), 48'(exp_bus(m_owner[k])));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; req = 3'b000; req_offset = 24'hC3B2A1;
    req_length = 3'b101; req_wr = 3'b110; req_wdata = 48'hCCCC_BBBB_AAAA;
    req_newcmd = 3'b000; req_dummy = 3'b010; seq_state = WAIT_ST;
    tick(2);
    chk("reset_grant", 48'(if_a.grant), 48'h0);
    chk("reset_busy", 48'(if_a.busy), 48'h0);
    reset = 1'b0;

    // reset during an rx grant
    req = 3'b100;
    tick(1);
    chk("rx_grant", 48'(if_a.grant), 48'h4);
    chk("rx_offset", 48'(if_a.offset), 48'hC3);
    req_newcmd = 3'b100;
    #1;
    chk("rx_newcmd", 48'(if_a.NewCommand), 48'h1);
    reset = 1'b1;
    tick(1);
    chk("midreset_grant", 48'(if_a.grant), 48'h0);
    chk("midreset_busy", 48'(if_a.busy), 48'h0);
    chk("midreset_newcmd", 48'(if_a.NewCommand), 48'h0);
    chk("midreset_wdata", 48'(if_a.writeData), 48'h0);
    reset = 1'b0; req_newcmd = 3'b000;

    // tx vs rx tie right after reset: tx wins, rx follows 3 edges after release
    req = 3'b110;
    tick(1);
    chk("tie_tx_grant", 48'(if_a.grant), 48'h2);
    chk("tie_tx_wdata", 48'(if_a.writeData), 48'hBBBB);
    tick(3);
    req = 3'b100;
    tick(1);
    chk("tx_release", 48'(if_a.grant), 48'h0);
    tick(2);
    chk("gap_grant", 48'(if_a.grant), 48'h0);
    tick(1);
    chk("rx_after_gap", 48'(if_a.grant), 48'h4);
    chk("rx_after_gap_offset", 48'(if_a.offset), 48'hC3);
    req = 3'b000;
    tick(5);

    // all three request: init first, then tx, then rx
    req = 3'b111;
    tick(1);
    chk("all_init_grant", 48'(if_a.grant), 48'h1);
    chk("all_init_offset", 48'(if_a.offset), 48'hA1);
    tick(19);
    req = 3'b110;
    tick(1);
    chk("init_release", 48'(if_a.grant), 48'h0);
    tick(3);
    chk("all_tx_grant", 48'(if_a.grant), 48'h2);
    tick(3);
    req = 3'b100;
    tick(3);
    chk("all_rx_pending", 48'(if_a.grant), 48'h0);
    tick(1);
    chk("all_rx_grant", 48'(if_a.grant), 48'h4);
    req = 3'b000;
    tick(5);

    // tx drops req while NewCommand high; sequencer busy in DRAIN
    req = 3'b010;
    tick(1);
    chk("nc_tx_grant", 48'(if_a.grant), 48'h2);
    req_newcmd = 3'b010; req = 3'b000;
    tick(3);
    chk("nc_hold", 48'(if_a.grant), 48'h2);
    req_newcmd = 3'b000; seq_state = READ1_ST; req = 3'b001;
    tick(1);
    chk("nc_release", 48'(if_a.grant), 48'h0);
    tick(5);
    chk("drain_no_grant", 48'(if_a.grant), 48'h0);
    chk("drain_busy", 48'(if_a.busy), 48'h1);
    seq_state = WAIT_ST;
    tick(2);
    chk("guard_no_grant", 48'(if_a.grant), 48'h0);
    tick(1);
    chk("post_drain_init", 48'(if_a.grant), 48'h1);
    req = 3'b000;
    tick(5);

    // watchdog on dut_b: rx holds forever, tx pending
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    req = 3'b100;
    tick(1);
    chk("wd_rx_grant", 48'(if_b.grant), 48'h4);
    req = 3'b110;
    tick(15);
    chk("wd_still_held", 48'(if_b.grant), 48'h4);
    chk("wd_no_err_yet", 48'(if_b.timeout_err), 48'h0);
    tick(1);
    chk("wd_drop", 48'(if_b.grant), 48'h0);
    chk("wd_err_pulse", 48'(if_b.timeout_err), 48'h1);
    chk("wd_owner", 48'(if_b.timeout_owner), 48'h2);
    chk("wd_a_holds", 48'(if_a.grant), 48'h4);
    tick(1);
    chk("wd_err_clear", 48'(if_b.timeout_err), 48'h0);
    tick(1);
    chk("wd_guard", 48'(if_b.grant), 48'h0);
    tick(1);
    chk("wd_tx_grant", 48'(if_b.grant), 48'h2);

    // timeout coinciding with release on dut_b
    req = 3'b000;
    tick(6);
    chk("wd_owner_sticky", 48'(if_b.timeout_owner), 48'h2);
    chk("idle_busy", 48'(if_b.busy), 48'h0);
    req = 3'b001;
    tick(1);
    chk("co_init_grant", 48'(if_b.grant), 48'h1);
    tick(15);
    req = 3'b000;
    tick(1);
    chk("co_err_pulse", 48'(if_b.timeout_err), 48'h1);
    chk("co_owner", 48'(if_b.timeout_owner), 48'h0);
    chk("co_grant", 48'(if_b.grant), 48'h0);
    chk("co_a_no_err", 48'(if_a.timeout_err), 48'h0);
    req = 3'b010;
    tick(1);
    chk("co_err_clear", 48'(if_b.timeout_err), 48'h0);
    tick(1);
    chk("co_guard_done", 48'(if_b.busy), 48'h0);
    chk("co_guard_grant", 48'(if_b.grant), 48'h0);
    tick(1);
    chk("co_tx_grant", 48'(if_b.grant), 48'h2);
    req = 3'b000;
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
